// File: rtl/sseg_pkg.sv
// Shared constants for the scanned 7-segment driver.
// Provides the segment bit positions, the hex font and the digit index type.
package sseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  // Active-high font, bit0 = a ... bit6 = g; lower-case b and d keep 6/8 and B/D apart.
  localparam logic [SEG_W-1:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Wide enough for up to eight digits.
  typedef logic [2:0] digit_idx_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Signal bundle between design logic and the scanned display driver.
// load is a one-cycle request that is always accepted (no ready); pending
// reports that a capture is waiting for the next frame boundary.
interface sseg_scan_mux_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank_lz;
  logic                    blink_en;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    pending;
  logic                    frame;

  modport master (
    output value, dp, load, blank_lz, blink_en,
    input  seg, dp_out, digit_sel, pending, frame
  );

  modport slave (
    input  value, dp, load, blank_lz, blink_en,
    output seg, dp_out, digit_sel, pending, frame
  );
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = HEX_FONT[nibble_i];
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// N-digit time-multiplexed 7-segment driver with tear-free loading,
// leading-zero blanking and frame-based blinking.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic                    blink_en_i,
  output logic [SEG_W-1:0]        seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    pending_o,
  output logic                    frame_o
);

  localparam int TW = cnt_width(REFRESH_DIV);
  localparam int FW = cnt_width(BLINK_FRAMES);
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam digit_idx_t    IDX_LAST   = digit_idx_t'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_q, tick_d;
  digit_idx_t              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_q, pend_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    phase_q, phase_d;

  logic                    tick_last;
  logic                    wrap;

  assign tick_last = (tick_q == TICK_LAST);
  assign wrap      = tick_last && (idx_q == IDX_LAST);

  always_comb begin
    tick_d      = tick_q;
    idx_d       = idx_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;

    if (tick_last) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + digit_idx_t'(1);
    end else begin
      tick_d = tick_q + TW'(1);
    end

    // The display register only changes on the wrap edge so a frame never mixes old and new digits.
    if (wrap) begin
      pend_d = 1'b0;
      if (load_i) begin
        disp_val_d = value_i;
        disp_dp_d  = dp_i;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end else if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= '0;
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  logic [3:0]       sel_nib;
  logic             sel_dp;
  logic             sel_blank;
  logic             upper_zero;
  logic [SEG_W-1:0] font_seg;
  logic             blink_off;

  // Walking down from the top digit, upper_zero means nibbles i..N-1 are all zero.
  always_comb begin
    sel_nib    = '0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
      if (idx_q == digit_idx_t'(i)) begin
        sel_nib   = disp_val_q[4*i +: 4];
        sel_dp    = disp_dp_q[i];
        sel_blank = blank_lz_i && (i != 0) && upper_zero;
      end
    end
  end

  always_comb begin
    digit_sel_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sel_o[i] = (idx_q == digit_idx_t'(i));
    end
  end

  sseg_hex_decode u_hex_decode (
    .nibble_i (sel_nib),
    .seg_o    (font_seg)
  );

  assign blink_off = blink_en_i && phase_q;
  assign seg_o     = (sel_blank || blink_off) ? '0 : font_seg;
  assign dp_o      = blink_off ? 1'b0 : sel_dp;
  assign pending_o = pend_q;
  assign frame_o   = wrap;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux: a 2-digit instance for scan/load/blink/reset
// and a 4-digit instance for leading-zero blanking.
module tb_sseg_scan_mux;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  sseg_scan_mux_if #(.NUM_DIGITS(2)) bus_a ();
  sseg_scan_mux_if #(.NUM_DIGITS(4)) bus_b ();

  sseg_scan_mux #(.NUM_DIGITS(2), .REFRESH_DIV(2), .BLINK_FRAMES(2)) dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .value_i     (bus_a.value),
    .dp_i        (bus_a.dp),
    .load_i      (bus_a.load),
    .blank_lz_i  (bus_a.blank_lz),
    .blink_en_i  (bus_a.blink_en),
    .seg_o       (bus_a.seg),
    .dp_o        (bus_a.dp_out),
    .digit_sel_o (bus_a.digit_sel),
    .pending_o   (bus_a.pending),
    .frame_o     (bus_a.frame)
  );

  sseg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLINK_FRAMES(64)) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .value_i     (bus_b.value),
    .dp_i        (bus_b.dp),
    .load_i      (bus_b.load),
    .blank_lz_i  (bus_b.blank_lz),
    .blink_en_i  (bus_b.blink_en),
    .seg_o       (bus_b.seg),
    .dp_o        (bus_b.dp_out),
    .digit_sel_o (bus_b.digit_sel),
    .pending_o   (bus_b.pending),
    .frame_o     (bus_b.frame)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] font [16];
  logic [6:0] exp_q [$];

  typedef struct {
    logic       load;
    logic [7:0] value;
    logic [1:0] dp;
    logic [1:0] sel;
    logic [6:0] seg;
    logic       dpo;
    logic       pend;
    logic       frame;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] exp_seg;
    logic [3:0] nib;
    logic       on;
    int         idx;
    logic [6:0] b_seg [4];
    logic       b_dp [4];

    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    //           load  value  dp     sel    seg    dpo   pend  frame
    vecs[0]  = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h3F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h3F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h3F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h3F, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'h47, 2'b00, 2'b01, 7'h3F, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h3F, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h3F, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h3F, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h07, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h07, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h66, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'hA3, 2'b01, 2'b10, 7'h66, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h4F, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h12, 2'b00, 2'b01, 7'h4F, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h9C, 2'b10, 2'b10, 7'h77, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h77, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h39, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 2'b00, 2'b01, 7'h39, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h6F, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 2'b00, 2'b10, 7'h6F, 1'b1, 1'b0, 1'b1};

    bus_a.value = '0; bus_a.dp = '0; bus_a.load = 1'b0;
    bus_a.blank_lz = 1'b0; bus_a.blink_en = 1'b0;
    bus_b.value = '0; bus_b.dp = '0; bus_b.load = 1'b0;
    bus_b.blank_lz = 1'b0; bus_b.blink_en = 1'b0;

    // Clock and reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;

    // Table: reset state, idle scan, mid-frame load, wrap-edge load, last load wins
    for (int k = 0; k < 20; k++) begin
      check($sformatf("tbl%0d_sel", k), 32'(bus_a.digit_sel), 32'(vecs[k].sel));
      check($sformatf("tbl%0d_seg", k), 32'(bus_a.seg), 32'(vecs[k].seg));
      check($sformatf("tbl%0d_dp", k), 32'(bus_a.dp_out), 32'(vecs[k].dpo));
      check($sformatf("tbl%0d_pend", k), 32'(bus_a.pending), 32'(vecs[k].pend));
      check($sformatf("tbl%0d_frame", k), 32'(bus_a.frame), 32'(vecs[k].frame));
      bus_a.load  = vecs[k].load;
      bus_a.value = vecs[k].value;
      bus_a.dp    = vecs[k].dp;
      step();
    end
    bus_a.load = 1'b0;

    // Reset while a load is pending and idx=1: the pending value must never appear
    bus_a.load = 1'b1; bus_a.value = 8'h88; bus_a.dp = 2'b11;
    step();
    bus_a.load = 1'b0;
    check("rst_pend_before", 32'(bus_a.pending), 32'd1);
    step();
    check("rst_idx1_before", 32'(bus_a.digit_sel), 32'h2);
    check("rst_pend_idx1", 32'(bus_a.pending), 32'd1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("rst_sel", 32'(bus_a.digit_sel), 32'h1);
    check("rst_seg", 32'(bus_a.seg), 32'h3F);
    check("rst_dp", 32'(bus_a.dp_out), 32'd0);
    check("rst_pend", 32'(bus_a.pending), 32'd0);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rst_after%0d_seg", c), 32'(bus_a.seg), 32'h3F);
      check($sformatf("rst_after%0d_dp", c), 32'(bus_a.dp_out), 32'd0);
      step();
    end

    // Blink with BLINK_FRAMES=2: on for frames 0,1, off for 2,3, on 4,5, off 6,7
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    bus_a.blink_en = 1'b1;
    bus_a.load = 1'b1; bus_a.value = 8'h47; bus_a.dp = 2'b11;
    for (int c = 0; c < 32; c++) begin
      idx = (c / 2) % 2;
      on  = (((c / 4) / 2) % 2) == 0;
      nib = (c < 4) ? 4'h0 : ((idx == 0) ? 4'h7 : 4'h4);
      exp_q.push_back(on ? font[nib] : 7'h00);
    end
    for (int c = 0; c < 32; c++) begin
      idx = (c / 2) % 2;
      on  = (((c / 4) / 2) % 2) == 0;
      exp_seg = exp_q.pop_front();
      check($sformatf("blink%0d_seg", c), 32'(bus_a.seg), 32'(exp_seg));
      check($sformatf("blink%0d_dp", c), 32'(bus_a.dp_out), 32'((on && c >= 4) ? 1 : 0));
      check($sformatf("blink%0d_sel", c), 32'(bus_a.digit_sel), 32'(1 << idx));
      step();
      bus_a.load = 1'b0;
    end
    bus_a.blink_en = 1'b0;

    // Leading-zero blanking on the 4-digit instance (REFRESH_DIV=1)
    rst_b = 1'b0;
    check("b_rst_sel", 32'(bus_b.digit_sel), 32'h1);
    check("b_rst_seg", 32'(bus_b.seg), 32'h3F);
    check("b_rst_frame", 32'(bus_b.frame), 32'd0);
    check("b_rst_pend", 32'(bus_b.pending), 32'd0);
    bus_b.blank_lz = 1'b1;
    bus_b.load = 1'b1; bus_b.value = 16'h0050; bus_b.dp = 4'b0100;
    step();
    bus_b.load = 1'b0;
    b_seg = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    b_dp  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 1; c < 16; c++) begin
      idx = c % 4;
      if (c == 12) begin
        bus_b.blank_lz = 1'b0;
        b_seg = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
      end
      if (c < 4) begin
        exp_seg = 7'h00;
      end else begin
        exp_seg = b_seg[idx];
      end
      check($sformatf("lz%0d_sel", c), 32'(bus_b.digit_sel), 32'(1 << idx));
      check($sformatf("lz%0d_seg", c), 32'(bus_b.seg), 32'(exp_seg));
      check($sformatf("lz%0d_dp", c), 32'(bus_b.dp_out), 32'((c >= 4) ? b_dp[idx] : 1'b0));
      check($sformatf("lz%0d_pend", c), 32'(bus_b.pending), 32'((c < 4) ? 1 : 0));
      check($sformatf("lz%0d_frame", c), 32'(bus_b.frame), 32'((idx == 3) ? 1 : 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Parametrised, time-multiplexed 7-segment display driver for the Tiny Tapeout / Virtual FPGA Lab board flow. It generalises the fixed two-digit tens/ones alternation to N scanned digits with:
- programmable refresh divider
- hex decode
- leading-zero blanking
- per-digit decimal points
- frame-synchronous (tear-free) value loading
- optional blink

It sits between design logic and the `uo_out` segment pins.

## Interface
Parameters:
- `NUM_DIGITS`, default 2: number of scanned digits, 1..8.
- `REFRESH_DIV`, default 2: clk cycles each digit stays selected, ≥1.
- `BLINK_FRAMES`, default 64: frames per blink half-period, ≥1.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `value_i`  in  4*NUM_DIGITS  hex nibbles; nibble i belongs to digit i (digit 0 = least significant).
- `dp_i`  in  NUM_DIGITS  decimal-point enables, bit i for digit i.
- `load_i`  in  1  request to capture `value_i`/`dp_i`.
- `blank_lz_i`  in  1  enable leading-zero blanking.
- `blink_en_i`  in  1  enable blinking.
- `seg_o`  out  7  active-high segments; bit0=a … bit6=g.
- `dp_o`  out  1  active-high decimal point.
- `digit_sel_o`  out  NUM_DIGITS  one-hot active-high digit enable.
- `pending_o`  out  1  a captured load is waiting for the frame boundary.
- `frame_o`  out  1  one-cycle pulse in the last cycle of each frame.

## Operation
- **State registers:** tick counter, digit index `idx`, display register (value+dp), pending register (value+dp), `pending` flag, frame counter, blink `phase`.
- **Scan:**
  - tick counts 0..REFRESH_DIV-1.
  - At tick==REFRESH_DIV-1, tick returns to 0 and `idx` advances, wrapping NUM_DIGITS-1→0.
  - Wrap edge = edge where tick==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
- **Load:**
  - `load_i` on a non-wrap edge writes the pending register and sets `pending`.
  - On the next wrap edge, the pending register is copied to the display register and `pending` clears.
  - `load_i` on a wrap edge writes `value_i`/`dp_i` directly into the display register; `pending` ends 0.
  - A later load overwrites an earlier pending one; last load wins.
- **Decode:** nibble→segments, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Leading-zero blanking:** digit i>0 is blanked when `blank_lz_i` is set and display nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit drives seg=0; dp is unaffected.
- **Blink:**
  - Frame counter increments on each wrap edge.
  - When it reaches BLINK_FRAMES-1 it returns to 0 and `phase` toggles.
  - When `blink_en_i` and phase=1, seg_o=0 and dp_o=0. Scanning continues.
- **Outputs:**
  - `digit_sel_o` = 1<<idx.
  - seg_o/dp_o are decoded from the display nibble and dp bit at idx, combinationally from registered state and the live `blank_lz_i`/`blink_en_i`.
  - `frame_o` is high exactly when the next edge is a wrap edge.

## Timing
- **Reset values:** tick=0, idx=0, display=0, pending=0, phase=0, frame counter=0. Hence:
  - digit_sel_o = 1
  - seg_o = 3F
  - dp_o = 0
  - pending_o = 0
  - frame_o = 1 only if NUM_DIGITS=1 and REFRESH_DIV=1
- **Load latency:**
  - A mid-frame load is visible on the first cycle of the next frame.
  - A wrap-edge load is visible in the following cycle.
  - `pending_o` rises the cycle after the load.
- **Reset priority:** reset mid-frame or with a pending load takes priority over load and wrap. All state returns to the reset values on that edge.
- **Frame length:** NUM_DIGITS*REFRESH_DIV cycles. Blink period is 2*BLINK_FRAMES frames.
- **Board mapping:** the board wrapper for NUM_DIGITS=2 maps uo_out = {digit_sel_o[1], seg_o}, preserving the existing two-digit board mapping.

## Structure
- Package `sseg_pkg`:
  - segment bit-position constants
  - 16-entry hex font constant
  - `digit_idx_t` width helper
- Sub-module `sseg_hex_decode`: combinational nibble→7-bit segments using the package font, instantiated once on the selected nibble.

## Test plan
- **Reset/idle** (N=2, DIV=2, blank_lz=0): after reset, digit_sel 01,01,10,10,…; seg 3F on every cycle; frame_o high on every 4th cycle.
- **Mid-frame load** of value 0x47 at idx=0: pending_o=1 until wrap; then digit0 seg=07 and digit1 seg=66; pending_o=0.
- **Wrap-edge load** of 0xA3 coinciding with frame_o: next cycle digit0 seg=4F; pending_o stays 0.
- **Leading-zero blanking** (N=4, value 0x0050, blank_lz=1): digit3 and digit2 seg=00, digit1 seg=6D, digit0 seg=3F; dp_i=0b0100 lights dp only on digit2 despite blanking.
- **Blink** (BLINK_FRAMES=2, blink_en=1): segments on for 2 frames, 00 for 2 frames, repeating; digit_sel keeps scanning.
- **Reset mid-operation** with a pending load and idx=1: next cycle idx=0, seg=3F, pending_o=0; the pending value is never displayed.
